// File: rtl/arbiter_pkg.sv
// ============================================================================
// Module      : arbiter_pkg
// Description : Shared types and default widths for the cacheline arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbiter_pkg;

    localparam int c_addr_width_default = 32;
    localparam int c_line_width_default = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/arbiter_fsm.sv
// ============================================================================
// Module      : arbiter_fsm
// Description : Grant FSM with round-robin tie-break between I and D sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_fsm
    import arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_inst_req,
    input  logic   i_data_req,
    input  logic   i_pmem_resp,
    output logic   o_grant_valid,
    output grant_t o_grant_sel
);

    arb_state_t r_state;
    grant_t     r_last_grant;
    logic       r_grant_valid;
    grant_t     r_grant_sel;
    grant_t     w_pick;

    // On contention the side that did not win last time gets the grant.
    always_comb begin
        w_pick = INST;
        if (i_inst_req && i_data_req) begin
            w_pick = (r_last_grant == INST) ? DATA : INST;
        end else if (i_data_req) begin
            w_pick = DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_grant  <= INST;
            r_grant_valid <= 1'b0;
            r_grant_sel   <= INST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_inst_req || i_data_req) begin
                        r_grant_valid <= 1'b1;
                        r_grant_sel   <= w_pick;
                        r_last_grant  <= w_pick;
                        r_state       <= (w_pick == DATA) ? SERVE_D : SERVE_I;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Held regardless of the requester until memory answers.
                    if (i_pmem_resp) begin
                        r_grant_valid <= 1'b0;
                        r_state       <= RECOVER;
                    end
                end
                RECOVER: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_grant_valid <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign o_grant_valid = r_grant_valid;
    assign o_grant_sel   = r_grant_sel;

endmodule

`default_nettype wire

// File: rtl/cacheline_arbiter.sv
// ============================================================================
// Module      : cacheline_arbiter
// Description : Shares one line-wide memory port between I-cache and D-cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_arbiter
    import arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width_default,
    parameter int LINE_WIDTH = c_line_width_default,
    parameter bit ASSERT_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_read,
    input  logic [ADDR_WIDTH-1:0] inst_address,
    output logic [LINE_WIDTH-1:0] inst_rdata,
    output logic                  inst_resp,
    input  logic                  data_read,
    input  logic                  data_write,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [LINE_WIDTH-1:0] data_wdata,
    output logic [LINE_WIDTH-1:0] data_rdata,
    output logic                  data_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    logic   w_grant_valid;
    grant_t w_grant_sel;
    logic   w_serve_i;
    logic   w_serve_d;

    arbiter_fsm u_fsm (
        .clk           (clk),
        .rst           (rst),
        .i_inst_req    (inst_read),
        .i_data_req    (data_read | data_write),
        .i_pmem_resp   (pmem_resp),
        .o_grant_valid (w_grant_valid),
        .o_grant_sel   (w_grant_sel)
    );

    assign w_serve_i = w_grant_valid && (w_grant_sel == INST);
    assign w_serve_d = w_grant_valid && (w_grant_sel == DATA);

    // A write wins if the D side illegally raises both commands.
    assign pmem_read  = w_serve_i | (w_serve_d & data_read & ~data_write);
    assign pmem_write = w_serve_d & data_write;

    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        if (w_serve_i) begin
            pmem_address = inst_address;
        end else if (w_serve_d) begin
            pmem_address = data_address;
            pmem_wdata   = data_wdata;
        end
    end

    assign inst_resp  = w_serve_i & pmem_resp;
    assign data_resp  = w_serve_d & pmem_resp;
    assign inst_rdata = pmem_rdata;
    assign data_rdata = pmem_rdata;

    generate
        if (ASSERT_EN) begin : g_rw_check
            always_ff @(posedge clk) begin
                if (!rst) begin
                    assert (!(data_read && data_write))
                        else $error("cacheline_arbiter: data_read and data_write high together");
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/cacheline_arbiter.md
CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width of all address ports.
REQ-002 Parameter LINE_WIDTH, default 256, cacheline data width of all data ports.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset: synchronous, active-high.
REQ-005 inst_read  in  1  I-cache line fill request, held until inst_resp.
REQ-006 inst_address  in  ADDR_WIDTH  I-cache line address, stable while inst_read is high.
REQ-007 inst_rdata  out  LINE_WIDTH  fill data, valid when inst_resp is high.
REQ-008 inst_resp  out  1  one-cycle I-side completion pulse.
REQ-009 data_read, data_write  in  1 each  D-cache fill / writeback request, held until data_resp.
REQ-010 data_address  in  ADDR_WIDTH; data_wdata  in  LINE_WIDTH  D-side address and writeback line, both stable while requesting.
REQ-011 data_rdata  out  LINE_WIDTH; data_resp  out  1  D-side fill data and one-cycle completion pulse.
REQ-012 pmem_read, pmem_write  out  1 each  memory commands, level-held until pmem_resp.
REQ-013 pmem_address  out  ADDR_WIDTH; pmem_wdata  out  LINE_WIDTH  memory address and write line.
REQ-014 pmem_rdata  in  LINE_WIDTH; pmem_resp  in  1  memory read data and completion pulse.

Function
REQ-015 FSM states: IDLE, SERVE_I, SERVE_D, RECOVER.
REQ-016 IDLE: no request -> IDLE; only I pending -> SERVE_I; only D pending (read or write) -> SERVE_D; both pending -> the requester not granted last.
REQ-017 last_grant register, 1 bit, updated on each IDLE->SERVE_x transition; reset value INST, so D wins the first contention.
REQ-018 Grant is registered: a request first seen in IDLE at cycle N drives pmem_read/pmem_write from cycle N+1.
REQ-019 SERVE_I: pmem_read=1, pmem_write=0, pmem_address=inst_address, pmem_wdata=0.
REQ-020 SERVE_D: pmem_read=data_read & ~data_write, pmem_write=data_write, pmem_address=data_address, pmem_wdata=data_wdata.
REQ-021 data_read and data_write high together is illegal; write wins and a simulation-only assertion fires.
REQ-022 pmem_resp in SERVE_x drives x_resp=1 in the same cycle (combinational); next state RECOVER.
REQ-023 The non-granted requester's resp SHALL never assert; pmem_resp outside SERVE_x is ignored.
REQ-024 inst_rdata and data_rdata both wire to pmem_rdata; validity is defined only by the matching resp.
REQ-025 RECOVER lasts exactly one cycle with all pmem commands low, so the served requester can drop its request; RECOVER -> IDLE.
REQ-026 A request arriving while another is served waits, unchanged, and is granted from the next IDLE; worst-case added latency = one full transaction + 2 cycles.
REQ-027 Back-to-back contention alternates strictly I/D/I/D; neither side can be starved.
REQ-028 A requester deasserting before its resp (protocol violation) leaves the FSM in SERVE_x until pmem_resp arrives.

Reset
REQ-029 On rst: state=IDLE, last_grant=INST; all outputs 0 from the following cycle.
REQ-030 rst mid-transaction abandons the access; no x_resp pulse is generated for it, and a pmem_resp arriving after reset is ignored.

Structure
REQ-031 Shared package arbiter_pkg holds the state enum, the grant_t enum {INST, DATA}, and the ADDR_WIDTH/LINE_WIDTH defaults.
REQ-032 Split into two parts: FSM plus last_grant in sub-module arbiter_fsm (outputs grant_valid and grant_sel); the top module holds only the port muxes and resp routing.

Verification
REQ-033 I-only read 0x0000_1000, memory resp after 3 cycles -> pmem_read from cycle 1, pmem_address=0x1000, inst_resp one cycle with the line; data_resp stays 0.
REQ-034 I and D reads in the same cycle after reset -> D served first, then I; pmem_address sequence D addr then I addr, with one RECOVER cycle between them.
REQ-035 Continuous I and D requests for 6 transactions -> grants D,I,D,I,D,I.
REQ-036 D write of 0xA5-pattern line to 0x2000 -> pmem_write=1, pmem_read=0, pmem_wdata equals the line; data_resp pulses once.
REQ-037 rst asserted while SERVE_D is waiting -> next cycle pmem_* are 0 and state is IDLE; a later stray pmem_resp produces no resp.
REQ-038 data_read and data_write both high -> write issued and assertion fires.
